fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter: QUEUE_DEPTH, 4, instruction queue entries (power of two, >=2).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 rdy  input  1  global enable; low freezes all state.
REQ-005 rob_clear  input  1  pipeline flush request.
REQ-006 rob_new_pc  input  32  redirect PC, valid with rob_clear.
REQ-007 fetch_req  output  1  instruction fetch request to memory cache.
REQ-008 fetch_addr  output  32  PC being requested.
REQ-009 mem_ready  input  1  cache returns one instruction this cycle.
REQ-010 mem_instr  input  32  returned instruction word.
REQ-011 mem_instr_addr  input  32  address of returned word.
REQ-012 dec_valid  output  1  queue head valid to decoder.
REQ-013 dec_instr  output  32  head instruction.
REQ-014 dec_pc  output  32  head PC.
REQ-015 dec_pred_taken  output  1  head was redirected by static JAL prediction.
REQ-016 dec_ready  input  1  decoder consumes head this cycle.

Function
REQ-017 FSM states: IDLE (no request outstanding), WAIT (one request outstanding); at most one request outstanding at any time.
REQ-018 IDLE, count < QUEUE_DEPTH, no rob_clear: fetch_req=1, fetch_addr=pc, next state WAIT.
REQ-019 IDLE, count == QUEUE_DEPTH: fetch_req=0, stay IDLE.
REQ-020 WAIT: fetch_req held 1 and fetch_addr held at inflight PC up to and including the mem_ready cycle.
REQ-021 WAIT, mem_ready=1, mem_instr_addr == inflight PC: push {mem_instr, inflight PC, taken bit} at tail; next state IDLE; new request issued no earlier than next cycle.
REQ-022 WAIT, mem_ready=1, address mismatch: response dropped, no push, state IDLE, pc unchanged (refetch).
REQ-023 Next PC on accepted response: mem_instr[6:0]==7'b1101111 (JAL) -> pc + sign-extended J-immediate {imm[20],imm[10:1],imm[11],imm[19:12],0}, taken bit 1; otherwise pc+4, taken bit 0; 32-bit modulo wrap, no overflow flag.
REQ-024 Pop when dec_valid && dec_ready: head advances by one; pop on empty queue ignored.
REQ-025 Push and pop same cycle: both performed, count unchanged; valid when full, since a push only follows an issue made with count < QUEUE_DEPTH.
REQ-026 dec_valid = (count != 0); dec_instr/dec_pc/dec_pred_taken driven from head entry, 0 when empty.
REQ-027 Head/tail pointers wrap modulo QUEUE_DEPTH; count ranges 0..QUEUE_DEPTH, width log2(DEPTH)+1.
REQ-028 rob_clear=1 (rdy=1): queue emptied (count=0, head=tail=0), pc <= rob_new_pc, state IDLE, fetch_req=0 that cycle, same-cycle mem_ready and dec_ready ignored; fetch from rob_new_pc starts next cycle.
REQ-029 rob_clear has priority over every other event except rst.
REQ-030 rdy=0: no push, pop, PC or state change; outputs keep current values.

Reset
REQ-031 rst=1 at a rising edge: pc=0, state IDLE, count=0, head=tail=0, all entries invalid; takes priority over rdy and rob_clear.
REQ-032 During and after reset cycle: fetch_req=0, fetch_addr=0, dec_valid=0, dec_instr=0, dec_pc=0, dec_pred_taken=0.
REQ-033 Reset mid-WAIT: outstanding request abandoned; later mem_ready for that address discarded by mismatch or IDLE state.

Verification
REQ-034 Release rst, dec_ready=0, cache returns 32'h00000013 for each address -> requests at 0,4,8,12, then fetch_req stays 0 with count=4; dec_pc=0.
REQ-035 Queue full, dec_ready=1 one cycle -> count 3, next cycle fetch_req=1, fetch_addr=16.
REQ-036 Return 32'h0080006F (JAL +8) at pc 0x20 -> entry dec_pred_taken=1, next fetch_addr=0x28.
REQ-037 In WAIT at 0x40, rob_clear=1 with rob_new_pc=0x100 and mem_ready=1 same cycle -> no push, count=0, next cycle fetch_addr=0x100.
REQ-038 mem_ready with mem_instr_addr=0x44 while inflight 0x40 -> no push, refetch 0x40.
REQ-039 rdy=0 for 3 cycles with mem_ready pulsing -> count, pc, state unchanged; resume on rdy=1.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues one fetch at a time, predicts JAL
// targets statically, and buffers returned words for the decoder.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   rdy                global enable; low freezes all state
//   rob_clear          flush request, rob_new_pc is the redirect PC
//   fetch_req/addr     request to the cache, held until the response
//   mem_ready/instr/   one returned word and its address
//     mem_instr_addr
//   dec_valid/instr/   head entry presented to the decoder
//     pc/pred_taken
//   dec_ready          decoder consumes the head this cycle
module fetch_queue #(
   parameter int QUEUE_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        rob_clear,
   input  logic [31:0] rob_new_pc,
   output logic        fetch_req,
   output logic [31:0] fetch_addr,
   input  logic        mem_ready,
   input  logic [31:0] mem_instr,
   input  logic [31:0] mem_instr_addr,
   output logic        dec_valid,
   output logic [31:0] dec_instr,
   output logic [31:0] dec_pc,
   output logic        dec_pred_taken,
   input  logic        dec_ready
);

   localparam int AW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam logic [AW:0] FULL = (AW+1)'(QUEUE_DEPTH);
   localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t        state;
   logic [31:0]   pc;
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [AW:0]   count;

   logic [31:0] q_instr [QUEUE_DEPTH];
   logic [31:0] q_pc    [QUEUE_DEPTH];
   logic        q_taken [QUEUE_DEPTH];

   logic        full;
   logic        empty;
   logic        clr;
   logic        accept;
   logic        pop;
   logic        is_jal;
   logic [31:0] j_imm;
   logic [31:0] next_pc;
   logic        unused_bits;

   assign full   = (count == FULL);
   assign empty  = (count == '0);
   assign clr    = rdy & rob_clear;
   assign pop    = ~empty & dec_ready;

   // Only a response whose address matches the inflight PC is kept;
   // anything else is stale and forces a refetch of the same PC.
   assign accept = (state == WAIT) & mem_ready
                 & (mem_instr_addr == pc);

   assign is_jal = (mem_instr[6:0] == 7'b1101111);
   assign j_imm  = {{11{mem_instr[31]}}, mem_instr[31],
                    mem_instr[19:12], mem_instr[20],
                    mem_instr[30:21], 1'b0};
   assign next_pc = is_jal ? (pc + j_imm) : (pc + 32'd4);

   assign unused_bits = ^mem_instr[11:7];

   // While waiting, pc still holds the inflight address.
   assign fetch_req  = ~rst & ~clr & ((state == WAIT) | ~full);
   assign fetch_addr = rst ? 32'd0 : pc;

   assign dec_valid      = ~rst & ~empty;
   assign dec_instr      = dec_valid ? q_instr[head] : 32'd0;
   assign dec_pc         = dec_valid ? q_pc[head] : 32'd0;
   assign dec_pred_taken = dec_valid ? q_taken[head] : 1'b0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         pc    <= 32'd0;
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            q_instr[i] <= 32'd0;
            q_pc[i]    <= 32'd0;
            q_taken[i] <= 1'b0;
         end
      end else if (rdy) begin
         if (rob_clear) begin
            state <= IDLE;
            pc    <= rob_new_pc;
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (!full) state <= WAIT;
               end
               WAIT: begin
                  if (mem_ready) begin
                     state <= IDLE;
                     if (accept) pc <= next_pc;
                  end
               end
            endcase

            if (accept) begin
               q_instr[tail] <= mem_instr;
               q_pc[tail]    <= pc;
               q_taken[tail] <= is_jal;
               tail          <= tail + PTR_ONE;
            end
            if (pop) head <= head + PTR_ONE;

            unique case (1'b1)
               (accept & ~pop): count <= count + CNT_ONE;
               (pop & ~accept): count <= count - CNT_ONE;
               default:         count <= count;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_fetch_queue;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        rob_clear;
   logic [31:0] rob_new_pc;
   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic        mem_ready;
   logic [31:0] mem_instr;
   logic [31:0] mem_instr_addr;
   logic        dec_valid;
   logic [31:0] dec_instr;
   logic [31:0] dec_pc;
   logic        dec_pred_taken;
   logic        dec_ready;

   fetch_queue #(.QUEUE_DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .rdy            (rdy),
      .rob_clear      (rob_clear),
      .rob_new_pc     (rob_new_pc),
      .fetch_req      (fetch_req),
      .fetch_addr     (fetch_addr),
      .mem_ready      (mem_ready),
      .mem_instr      (mem_instr),
      .mem_instr_addr (mem_instr_addr),
      .dec_valid      (dec_valid),
      .dec_instr      (dec_instr),
      .dec_pc         (dec_pc),
      .dec_pred_taken (dec_pred_taken),
      .dec_ready      (dec_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Reference model: a plain FIFO of fetched words plus a PC and an
   // "a request is outstanding" flag.
   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      bit          taken;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_pc = 32'd0;
   bit          m_busy = 1'b0;
   int          m_sz;
   bit          m_jal;

   function automatic logic [31:0] jimm(input logic [31:0] w);
      int v;
      v = int'(w[30:21]) * 2 + int'(w[20]) * 2048
        + int'(w[19:12]) * 4096;
      if (w[31]) v = v - 1048576;
      return 32'(v);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         m_pc   = 32'd0;
         m_busy = 1'b0;
      end else if (rdy) begin
         if (rob_clear) begin
            mq.delete();
            m_pc   = rob_new_pc;
            m_busy = 1'b0;
         end else begin
            m_sz = mq.size();
            if (m_sz > 0 && dec_ready) void'(mq.pop_front());
            if (m_busy && mem_ready) begin
               if (mem_instr_addr == m_pc) begin
                  m_jal = (mem_instr[6:0] == 7'h6F);
                  mq.push_back('{mem_instr, m_pc, m_jal});
                  m_pc = m_jal ? m_pc + jimm(mem_instr)
                               : m_pc + 32'd4;
               end
               m_busy = 1'b0;
            end else if (!m_busy && m_sz < DEPTH) begin
               m_busy = 1'b1;
            end
         end
      end
   end

   bit          e_req;
   bit          e_val;
   logic [31:0] e_addr;

   always @(negedge clk) begin
      e_req  = !rst && !(rdy && rob_clear)
             && (m_busy || mq.size() < DEPTH);
      e_addr = rst ? 32'd0 : m_pc;
      e_val  = !rst && mq.size() > 0;
      chk("cyc fetch_req", 32'(fetch_req), 32'(e_req));
      chk("cyc fetch_addr", fetch_addr, e_addr);
      chk("cyc dec_valid", 32'(dec_valid), 32'(e_val));
      chk("cyc dec_instr", dec_instr,
          e_val ? mq[0].instr : 32'd0);
      chk("cyc dec_pc", dec_pc, e_val ? mq[0].pc : 32'd0);
      chk("cyc dec_pred", 32'(dec_pred_taken),
          e_val ? 32'(mq[0].taken) : 32'd0);
   end

   // Cache responder: answers a request one cycle after it is seen.
   bit          s_req;
   bit          s_rdy;
   logic [31:0] s_addr;
   bit          auto_mem;

   always @(negedge clk) begin
      s_req  = fetch_req;
      s_rdy  = mem_ready;
      s_addr = fetch_addr;
   end

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a == 32'h20) ? 32'h0080006F : 32'h00000013;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      if (auto_mem) begin
         mem_ready      = s_req && !s_rdy;
         mem_instr_addr = s_addr;
         mem_instr      = memf(s_addr);
      end
   endtask

   task automatic settle();
      #2;
   endtask

   initial begin
      rst            = 1'b1;
      rdy            = 1'b1;
      rob_clear      = 1'b0;
      rob_new_pc     = 32'd0;
      mem_ready      = 1'b0;
      mem_instr      = 32'd0;
      mem_instr_addr = 32'd0;
      dec_ready      = 1'b0;
      auto_mem       = 1'b1;

      // reset state
      step();
      settle();
      chk("rst fetch_req", 32'(fetch_req), 32'd0);
      chk("rst fetch_addr", fetch_addr, 32'd0);
      chk("rst dec_valid", 32'(dec_valid), 32'd0);
      step();
      rst = 1'b0;
      settle();
      chk("first req", 32'(fetch_req), 32'd1);
      chk("first addr", fetch_addr, 32'd0);

      // fill: requests at 0,4,8,12 then stop
      for (int i = 0; i < 12; i++) step();
      settle();
      chk("full no req", 32'(fetch_req), 32'd0);
      chk("full dec_pc", dec_pc, 32'd0);
      chk("full dec_instr", dec_instr, 32'h13);
      chk("model size 4", 32'(mq.size()), 32'd4);

      // one pop from full
      dec_ready = 1'b1;
      step();
      dec_ready = 1'b0;
      settle();
      chk("pop model size", 32'(mq.size()), 32'd3);
      chk("pop dec_pc", dec_pc, 32'd4);
      chk("pop req", 32'(fetch_req), 32'd1);
      chk("pop addr 16", fetch_addr, 32'd16);
      for (int i = 0; i < 3; i++) step();

      // JAL prediction at 0x20
      rob_clear  = 1'b1;
      rob_new_pc = 32'h20;
      settle();
      chk("clr req low", 32'(fetch_req), 32'd0);
      step();
      rob_clear = 1'b0;
      settle();
      chk("redir addr", fetch_addr, 32'h20);
      chk("redir empty", 32'(dec_valid), 32'd0);
      step();
      step();
      settle();
      chk("jal dec_pc", dec_pc, 32'h20);
      chk("jal instr", dec_instr, 32'h0080006F);
      chk("jal taken", 32'(dec_pred_taken), 32'd1);
      chk("jal target", fetch_addr, 32'h28);

      // flush while a response arrives
      rob_clear  = 1'b1;
      rob_new_pc = 32'h40;
      step();
      rob_clear = 1'b0;
      step();
      settle();
      chk("wait40 ready", 32'(mem_ready), 32'd1);
      rob_clear  = 1'b1;
      rob_new_pc = 32'h100;
      settle();
      chk("flush req low", 32'(fetch_req), 32'd0);
      step();
      rob_clear = 1'b0;
      settle();
      chk("flush no push", 32'(dec_valid), 32'd0);
      chk("flush addr", fetch_addr, 32'h100);
      chk("flush req", 32'(fetch_req), 32'd1);

      // mismatched response address
      auto_mem   = 1'b0;
      mem_ready  = 1'b0;
      rob_clear  = 1'b1;
      rob_new_pc = 32'h40;
      step();
      rob_clear = 1'b0;
      step();
      mem_ready      = 1'b1;
      mem_instr_addr = 32'h44;
      mem_instr      = 32'h13;
      step();
      mem_ready = 1'b0;
      settle();
      chk("mism no push", 32'(dec_valid), 32'd0);
      chk("mism refetch", fetch_addr, 32'h40);
      chk("mism req", 32'(fetch_req), 32'd1);
      step();
      mem_ready      = 1'b1;
      mem_instr_addr = 32'h40;
      step();
      mem_ready = 1'b0;
      settle();
      chk("match pc", dec_pc, 32'h40);
      chk("match next", fetch_addr, 32'h44);

      // freeze with rdy low
      step();
      rdy       = 1'b0;
      dec_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         mem_ready      = (i != 1);
         mem_instr_addr = 32'h44;
         step();
         settle();
         chk("frz req", 32'(fetch_req), 32'd1);
         chk("frz addr", fetch_addr, 32'h44);
         chk("frz dec_pc", dec_pc, 32'h40);
      end
      rdy       = 1'b1;
      dec_ready = 1'b0;
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      settle();
      chk("resume size", 32'(mq.size()), 32'd2);
      chk("resume head", dec_pc, 32'h40);
      chk("resume next", fetch_addr, 32'h48);

      // reset while waiting; stale response ignored
      step();
      rst = 1'b1;
      settle();
      chk("rstw req", 32'(fetch_req), 32'd0);
      chk("rstw valid", 32'(dec_valid), 32'd0);
      step();
      rst            = 1'b0;
      mem_ready      = 1'b1;
      mem_instr_addr = 32'h48;
      step();
      mem_ready = 1'b0;
      settle();
      chk("stale no push", 32'(dec_valid), 32'd0);
      chk("stale addr", fetch_addr, 32'd0);
      chk("stale req", 32'(fetch_req), 32'd1);

      // steady streaming with periodic consumption
      auto_mem = 1'b1;
      for (int i = 0; i < 40; i++) begin
         dec_ready = (i % 3 == 0);
         step();
      end
      dec_ready = 1'b0;
      step();
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
